// File: rtl/ysyx_25050136_axi_pkg.sv
// State encodings and round-robin search shared by the AXI arbiter and its picker.
package ysyx_25050136_axi_pkg;

    localparam int MAX_M = 8;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_e;

    // Returns {found, index} of the first request at or after ptr, wrapping at n.
    function automatic logic [3:0] rr_first(input logic [MAX_M-1:0] req,
                                            input logic [2:0]       ptr,
                                            input int               n);
        logic [3:0] res;
        logic [3:0] pos;
        res = '0;
        for (int k = 0; k < MAX_M; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(n)) pos = pos - 4'(n);
            if (k < n && !res[3] && req[pos[2:0]]) res = {1'b1, pos[2:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_25050136_rr_pick.sv
// Combinational round-robin pick: first request at or after ptr_i, as one-hot and index.
// No state, no backpressure; vld_o is low when no request is pending.
module ysyx_25050136_rr_pick
    import ysyx_25050136_axi_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    logic [MAX_M-1:0] req_ext;
    logic [3:0]       res;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
    end

    assign res   = rr_first(req_ext, 3'(ptr_i), N);
    assign vld_o = res[3];
    assign idx_o = IW'(res[2:0]);
    assign gnt_o = vld_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/ysyx_25050136_axi_arb_rr.sv
// N-to-1 AXI4 round-robin arbiter; one cycle of grant latency per transaction, then
// combinational grant-muxed channels, so ready/valid backpressure passes straight through.
module ysyx_25050136_axi_arb_rr
    import ysyx_25050136_axi_pkg::*;
#(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [MASTER_NUM-1:0]        s_awvalid_i,
    input  logic [MASTER_NUM*ADDR_W-1:0] s_awaddr_i,
    input  logic [MASTER_NUM*ID_W-1:0]   s_awid_i,
    input  logic [MASTER_NUM*8-1:0]      s_awlen_i,
    input  logic [MASTER_NUM*3-1:0]      s_awsize_i,
    input  logic [MASTER_NUM*2-1:0]      s_awburst_i,
    output logic [MASTER_NUM-1:0]        s_awready_o,

    input  logic [MASTER_NUM-1:0]          s_wvalid_i,
    input  logic [MASTER_NUM*DATA_W-1:0]   s_wdata_i,
    input  logic [MASTER_NUM*DATA_W/8-1:0] s_wstrb_i,
    input  logic [MASTER_NUM-1:0]          s_wlast_i,
    output logic [MASTER_NUM-1:0]          s_wready_o,

    output logic [MASTER_NUM-1:0]        s_bvalid_o,
    output logic [MASTER_NUM*2-1:0]      s_bresp_o,
    output logic [MASTER_NUM*ID_W-1:0]   s_bid_o,
    input  logic [MASTER_NUM-1:0]        s_bready_i,

    input  logic [MASTER_NUM-1:0]        s_arvalid_i,
    input  logic [MASTER_NUM*ADDR_W-1:0] s_araddr_i,
    input  logic [MASTER_NUM*ID_W-1:0]   s_arid_i,
    input  logic [MASTER_NUM*8-1:0]      s_arlen_i,
    input  logic [MASTER_NUM*3-1:0]      s_arsize_i,
    input  logic [MASTER_NUM*2-1:0]      s_arburst_i,
    output logic [MASTER_NUM-1:0]        s_arready_o,

    output logic [MASTER_NUM-1:0]        s_rvalid_o,
    output logic [MASTER_NUM*DATA_W-1:0] s_rdata_o,
    output logic [MASTER_NUM*2-1:0]      s_rresp_o,
    output logic [MASTER_NUM-1:0]        s_rlast_o,
    output logic [MASTER_NUM*ID_W-1:0]   s_rid_o,
    input  logic [MASTER_NUM-1:0]        s_rready_i,

    output logic                         m_awvalid_o,
    output logic [ADDR_W-1:0]            m_awaddr_o,
    output logic [ID_W-1:0]              m_awid_o,
    output logic [7:0]                   m_awlen_o,
    output logic [2:0]                   m_awsize_o,
    output logic [1:0]                   m_awburst_o,
    input  logic                         m_awready_i,

    output logic                         m_wvalid_o,
    output logic [DATA_W-1:0]            m_wdata_o,
    output logic [DATA_W/8-1:0]          m_wstrb_o,
    output logic                         m_wlast_o,
    input  logic                         m_wready_i,

    input  logic                         m_bvalid_i,
    input  logic [1:0]                   m_bresp_i,
    input  logic [ID_W-1:0]              m_bid_i,
    output logic                         m_bready_o,

    output logic                         m_arvalid_o,
    output logic [ADDR_W-1:0]            m_araddr_o,
    output logic [ID_W-1:0]              m_arid_o,
    output logic [7:0]                   m_arlen_o,
    output logic [2:0]                   m_arsize_o,
    output logic [1:0]                   m_arburst_o,
    input  logic                         m_arready_i,

    input  logic                         m_rvalid_i,
    input  logic [DATA_W-1:0]            m_rdata_i,
    input  logic [1:0]                   m_rresp_i,
    input  logic                         m_rlast_i,
    input  logic [ID_W-1:0]              m_rid_i,
    output logic                         m_rready_o
);

    localparam int IW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
    localparam int SW = DATA_W / 8;

    r_state_e                r_state_q;
    logic [IW-1:0]           r_idx_q, r_ptr_q, r_ptr_d;
    logic [MASTER_NUM-1:0]   r_oh_q;
    logic [MASTER_NUM-1:0]   r_pick_gnt;
    logic [IW-1:0]           r_pick_idx;
    logic                    r_pick_vld;
    int                      r_sel;

    w_state_e                w_state_q;
    logic [IW-1:0]           w_idx_q, w_ptr_q, w_ptr_d;
    logic [MASTER_NUM-1:0]   w_oh_q;
    logic [MASTER_NUM-1:0]   w_pick_gnt;
    logic [IW-1:0]           w_pick_idx;
    logic                    w_pick_vld;
    int                      w_sel;

    ysyx_25050136_rr_pick #(.N(MASTER_NUM), .IW(IW)) u_r_pick (
        .req_i (s_arvalid_i),
        .ptr_i (r_ptr_q),
        .gnt_o (r_pick_gnt),
        .idx_o (r_pick_idx),
        .vld_o (r_pick_vld)
    );

    ysyx_25050136_rr_pick #(.N(MASTER_NUM), .IW(IW)) u_w_pick (
        .req_i (s_awvalid_i),
        .ptr_i (w_ptr_q),
        .gnt_o (w_pick_gnt),
        .idx_o (w_pick_idx),
        .vld_o (w_pick_vld)
    );

    assign r_sel   = int'(r_idx_q);
    assign w_sel   = int'(w_idx_q);
    assign r_ptr_d = (r_idx_q == IW'(MASTER_NUM - 1)) ? '0 : r_idx_q + IW'(1);
    assign w_ptr_d = (w_idx_q == IW'(MASTER_NUM - 1)) ? '0 : w_idx_q + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_oh_q    <= '0;
            r_ptr_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (r_pick_vld) begin
                    r_idx_q   <= r_pick_idx;
                    r_oh_q    <= r_pick_gnt;
                    r_state_q <= R_ADDR;
                end
                R_ADDR: if (m_arvalid_o && m_arready_i) r_state_q <= R_DATA;
                R_DATA: if (m_rvalid_i && m_rready_o && m_rlast_i) begin
                    r_state_q <= R_IDLE;
                    r_ptr_q   <= r_ptr_d;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_oh_q    <= '0;
            w_ptr_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: if (w_pick_vld) begin
                    w_idx_q   <= w_pick_idx;
                    w_oh_q    <= w_pick_gnt;
                    w_state_q <= W_ADDR;
                end
                W_ADDR: if (m_awvalid_o && m_awready_i) w_state_q <= W_DATA;
                W_DATA: if (m_wvalid_o && m_wready_i && m_wlast_o) w_state_q <= W_RESP;
                W_RESP: if (m_bvalid_i && m_bready_o) begin
                    w_state_q <= W_IDLE;
                    w_ptr_q   <= w_ptr_d;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Routing keys off the registered one-hot grant; returned IDs are never decoded.
    always_comb begin
        m_arvalid_o = 1'b0;
        m_araddr_o  = '0;
        m_arid_o    = '0;
        m_arlen_o   = '0;
        m_arsize_o  = '0;
        m_arburst_o = '0;
        m_rready_o  = 1'b0;
        s_arready_o = '0;
        s_rvalid_o  = '0;
        s_rdata_o   = '0;
        s_rresp_o   = '0;
        s_rlast_o   = '0;
        s_rid_o     = '0;
        case (r_state_q)
            R_ADDR: begin
                m_arvalid_o = |(s_arvalid_i & r_oh_q);
                m_araddr_o  = s_araddr_i[r_sel*ADDR_W +: ADDR_W];
                m_arid_o    = s_arid_i[r_sel*ID_W +: ID_W];
                m_arlen_o   = s_arlen_i[r_sel*8 +: 8];
                m_arsize_o  = s_arsize_i[r_sel*3 +: 3];
                m_arburst_o = s_arburst_i[r_sel*2 +: 2];
                s_arready_o = r_oh_q & {MASTER_NUM{m_arready_i}};
            end
            R_DATA: begin
                m_rready_o                        = |(s_rready_i & r_oh_q);
                s_rvalid_o                        = r_oh_q & {MASTER_NUM{m_rvalid_i}};
                s_rlast_o                         = r_oh_q & {MASTER_NUM{m_rlast_i}};
                s_rdata_o[r_sel*DATA_W +: DATA_W] = m_rdata_i;
                s_rresp_o[r_sel*2 +: 2]           = m_rresp_i;
                s_rid_o[r_sel*ID_W +: ID_W]       = m_rid_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        m_awvalid_o = 1'b0;
        m_awaddr_o  = '0;
        m_awid_o    = '0;
        m_awlen_o   = '0;
        m_awsize_o  = '0;
        m_awburst_o = '0;
        m_wvalid_o  = 1'b0;
        m_wdata_o   = '0;
        m_wstrb_o   = '0;
        m_wlast_o   = 1'b0;
        m_bready_o  = 1'b0;
        s_awready_o = '0;
        s_wready_o  = '0;
        s_bvalid_o  = '0;
        s_bresp_o   = '0;
        s_bid_o     = '0;
        case (w_state_q)
            W_ADDR: begin
                m_awvalid_o = |(s_awvalid_i & w_oh_q);
                m_awaddr_o  = s_awaddr_i[w_sel*ADDR_W +: ADDR_W];
                m_awid_o    = s_awid_i[w_sel*ID_W +: ID_W];
                m_awlen_o   = s_awlen_i[w_sel*8 +: 8];
                m_awsize_o  = s_awsize_i[w_sel*3 +: 3];
                m_awburst_o = s_awburst_i[w_sel*2 +: 2];
                s_awready_o = w_oh_q & {MASTER_NUM{m_awready_i}};
            end
            W_DATA: begin
                m_wvalid_o = |(s_wvalid_i & w_oh_q);
                m_wdata_o  = s_wdata_i[w_sel*DATA_W +: DATA_W];
                m_wstrb_o  = s_wstrb_i[w_sel*SW +: SW];
                m_wlast_o  = |(s_wlast_i & w_oh_q);
                s_wready_o = w_oh_q & {MASTER_NUM{m_wready_i}};
            end
            W_RESP: begin
                m_bready_o                  = |(s_bready_i & w_oh_q);
                s_bvalid_o                  = w_oh_q & {MASTER_NUM{m_bvalid_i}};
                s_bresp_o[w_sel*2 +: 2]     = m_bresp_i;
                s_bid_o[w_sel*ID_W +: ID_W] = m_bid_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25050136_axi_arb_rr.sv
// Directed bench: two-master arbiter for routing/ordering/reset scenarios, plus a
// four-master instance for round-robin fairness.
module tb_ysyx_25050136_axi_arb_rr;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [7:0]  s_awid, s_wstrb, s_bid, s_arid, s_rid;
    logic [15:0] s_awlen, s_arlen;
    logic [5:0]  s_awsize, s_arsize;
    logic [3:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_awid, m_wstrb, m_bid, m_arid, m_rid;
    logic [7:0]  m_awlen, m_arlen;
    logic [2:0]  m_awsize, m_arsize;
    logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;

    ysyx_25050136_axi_arb_rr #(.MASTER_NUM(2)) dut (
        .clk(clk), .reset(reset),
        .s_awvalid_i(s_awvalid), .s_awaddr_i(s_awaddr), .s_awid_i(s_awid), .s_awlen_i(s_awlen),
        .s_awsize_i(s_awsize), .s_awburst_i(s_awburst), .s_awready_o(s_awready),
        .s_wvalid_i(s_wvalid), .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wlast_i(s_wlast),
        .s_wready_o(s_wready),
        .s_bvalid_o(s_bvalid), .s_bresp_o(s_bresp), .s_bid_o(s_bid), .s_bready_i(s_bready),
        .s_arvalid_i(s_arvalid), .s_araddr_i(s_araddr), .s_arid_i(s_arid), .s_arlen_i(s_arlen),
        .s_arsize_i(s_arsize), .s_arburst_i(s_arburst), .s_arready_o(s_arready),
        .s_rvalid_o(s_rvalid), .s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rlast_o(s_rlast),
        .s_rid_o(s_rid), .s_rready_i(s_rready),
        .m_awvalid_o(m_awvalid), .m_awaddr_o(m_awaddr), .m_awid_o(m_awid), .m_awlen_o(m_awlen),
        .m_awsize_o(m_awsize), .m_awburst_o(m_awburst), .m_awready_i(m_awready),
        .m_wvalid_o(m_wvalid), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wlast_o(m_wlast),
        .m_wready_i(m_wready),
        .m_bvalid_i(m_bvalid), .m_bresp_i(m_bresp), .m_bid_i(m_bid), .m_bready_o(m_bready),
        .m_arvalid_o(m_arvalid), .m_araddr_o(m_araddr), .m_arid_o(m_arid), .m_arlen_o(m_arlen),
        .m_arsize_o(m_arsize), .m_arburst_o(m_arburst), .m_arready_i(m_arready),
        .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rlast_i(m_rlast),
        .m_rid_i(m_rid), .m_rready_o(m_rready)
    );

    logic [3:0]   q_s_awready, q_s_wready, q_s_bvalid, q_s_arvalid, q_s_arready;
    logic [3:0]   q_s_rvalid, q_s_rlast, q_s_rready;
    logic [7:0]   q_s_bresp, q_s_rresp;
    logic [15:0]  q_s_bid, q_s_arid, q_s_rid;
    logic [127:0] q_s_rdata;
    logic         q_m_awvalid, q_m_wvalid, q_m_wlast, q_m_bready, q_m_arvalid, q_m_rready;
    logic         q_m_arready, q_m_rvalid, q_m_rlast;
    logic [31:0]  q_m_awaddr, q_m_wdata, q_m_araddr;
    logic [3:0]   q_m_awid, q_m_wstrb, q_m_arid;
    logic [7:0]   q_m_awlen, q_m_arlen;
    logic [2:0]   q_m_awsize, q_m_arsize;
    logic [1:0]   q_m_awburst, q_m_arburst;

    ysyx_25050136_axi_arb_rr #(.MASTER_NUM(4)) dut4 (
        .clk(clk), .reset(reset),
        .s_awvalid_i('0), .s_awaddr_i('0), .s_awid_i('0), .s_awlen_i('0),
        .s_awsize_i('0), .s_awburst_i('0), .s_awready_o(q_s_awready),
        .s_wvalid_i('0), .s_wdata_i('0), .s_wstrb_i('0), .s_wlast_i('0), .s_wready_o(q_s_wready),
        .s_bvalid_o(q_s_bvalid), .s_bresp_o(q_s_bresp), .s_bid_o(q_s_bid), .s_bready_i('0),
        .s_arvalid_i(q_s_arvalid), .s_araddr_i('0), .s_arid_i(q_s_arid), .s_arlen_i('0),
        .s_arsize_i('0), .s_arburst_i('0), .s_arready_o(q_s_arready),
        .s_rvalid_o(q_s_rvalid), .s_rdata_o(q_s_rdata), .s_rresp_o(q_s_rresp),
        .s_rlast_o(q_s_rlast), .s_rid_o(q_s_rid), .s_rready_i(q_s_rready),
        .m_awvalid_o(q_m_awvalid), .m_awaddr_o(q_m_awaddr), .m_awid_o(q_m_awid),
        .m_awlen_o(q_m_awlen), .m_awsize_o(q_m_awsize), .m_awburst_o(q_m_awburst),
        .m_awready_i(1'b0),
        .m_wvalid_o(q_m_wvalid), .m_wdata_o(q_m_wdata), .m_wstrb_o(q_m_wstrb),
        .m_wlast_o(q_m_wlast), .m_wready_i(1'b0),
        .m_bvalid_i(1'b0), .m_bresp_i(2'b00), .m_bid_i(4'h0), .m_bready_o(q_m_bready),
        .m_arvalid_o(q_m_arvalid), .m_araddr_o(q_m_araddr), .m_arid_o(q_m_arid),
        .m_arlen_o(q_m_arlen), .m_arsize_o(q_m_arsize), .m_arburst_o(q_m_arburst),
        .m_arready_i(q_m_arready),
        .m_rvalid_i(q_m_rvalid), .m_rdata_i(32'h0), .m_rresp_i(2'b00), .m_rlast_i(q_m_rlast),
        .m_rid_i(4'h0), .m_rready_o(q_m_rready)
    );

    task automatic test_reset();
        checks++;
        if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_m_valid_ready got=%b exp=0", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready});
        end
        checks++;
        if ({s_arready, s_awready, s_wready, s_rvalid, s_bvalid, s_rlast} !== 12'b0) begin
            errors++;
            $display("FAIL reset_s_valid_ready got=%b exp=0", {s_arready, s_awready, s_wready, s_rvalid, s_bvalid, s_rlast});
        end
        checks++;
        if ((|{m_araddr, m_awaddr, m_wdata, m_wstrb, s_rdata, s_rresp, s_bresp, s_bid, s_rid}) !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got=nonzero exp=0");
        end
        checks++;
        if ({q_m_arvalid, q_m_rready, q_s_arready, q_s_rvalid} !== 10'b0) begin
            errors++;
            $display("FAIL reset_dut4 got=%b exp=0", {q_m_arvalid, q_m_rready, q_s_arready, q_s_rvalid});
        end
    endtask

    task automatic test_rr_two();
        @(negedge clk); s_arvalid = 2'b11; #1;
        checks++;
        if ({m_arvalid, s_arready} !== 3'b000) begin
            errors++; $display("FAIL rr2_cycle1 got=%b exp=000", {m_arvalid, s_arready});
        end
        @(negedge clk); #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000 || m_arid !== 4'h1 || s_arready !== 2'b01) begin
            errors++; $display("FAIL rr2_grant0 got=%b/%h/%h/%b exp=1/1000/1/01", m_arvalid, m_araddr, m_arid, s_arready);
        end
        @(negedge clk); s_arvalid[0] = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hAA; m_rlast = 1'b1; m_rid = 4'h1; #1;
        checks++;
        if (s_rvalid !== 2'b01 || s_rdata !== 64'h0000_0000_0000_00AA || s_rid !== 8'h01 || m_rready !== 1'b1) begin
            errors++; $display("FAIL rr2_rdata0 got=%b/%h/%h/%b exp=01/aa/01/1", s_rvalid, s_rdata, s_rid, m_rready);
        end
        @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0; #1;
        checks++;
        if (m_arvalid !== 1'b0) begin
            errors++; $display("FAIL rr2_idle_gap got=%b exp=0", m_arvalid);
        end
        @(negedge clk); #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h2000 || s_arready !== 2'b10) begin
            errors++; $display("FAIL rr2_grant1 got=%b/%h/%b exp=1/2000/10", m_arvalid, m_araddr, s_arready);
        end
        @(negedge clk); s_arvalid = 2'b00;
        m_rvalid = 1'b1; m_rdata = 32'hBB; m_rlast = 1'b1; m_rid = 4'h2; #1;
        checks++;
        if (s_rvalid !== 2'b10 || s_rdata !== 64'h0000_00BB_0000_0000 || s_rid !== 8'h20) begin
            errors++; $display("FAIL rr2_rdata1 got=%b/%h/%h exp=10/bb00000000/20", s_rvalid, s_rdata, s_rid);
        end
        @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    task automatic test_burst();
        logic [31:0] beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [3:0]  exp_resp;
        @(negedge clk); s_arvalid = 2'b10; s_arlen = 16'h0300;
        @(negedge clk); #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_arlen !== 8'd3 || s_arready !== 2'b10) begin
            errors++; $display("FAIL burst_ar got=%b/%0d/%b exp=1/3/10", m_arvalid, m_arlen, s_arready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); s_arvalid = 2'b00;
            m_rvalid = 1'b1; m_rdata = beats[i]; m_rlast = (i == 3);
            m_rresp = (i == 2) ? 2'b10 : 2'b00; #1;
            exp_resp = (i == 2) ? 4'b1000 : 4'b0000;
            checks++;
            if (s_rvalid !== 2'b10 || s_rdata[63:32] !== beats[i] || s_rdata[31:0] !== 32'h0 || s_rresp !== exp_resp) begin
                errors++; $display("FAIL burst_beat%0d got=%b/%h/%b exp=10/%h/%b", i, s_rvalid, s_rdata, s_rresp, beats[i], exp_resp);
            end
        end
        @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; s_arlen = 16'h0; #1;
        checks++;
        if (m_rready !== 1'b0 || m_arvalid !== 1'b0) begin
            errors++; $display("FAIL burst_done got=%b/%b exp=0/0", m_rready, m_arvalid);
        end
    endtask

    task automatic test_concurrent();
        @(negedge clk);
        s_arvalid = 2'b01; s_awvalid = 2'b10; s_wvalid = 2'b10; s_wlast = 2'b10;
        s_wdata = 64'h0000_CAFE_0000_0000; s_wstrb = 8'hF0; #1;
        checks++;
        if (m_awvalid !== 1'b0 || s_wready !== 2'b00) begin
            errors++; $display("FAIL conc_idle got=%b/%b exp=0/00", m_awvalid, s_wready);
        end
        @(negedge clk); #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000 || m_awvalid !== 1'b1 || m_awaddr !== 32'h4000 ||
            s_awready !== 2'b10 || s_wready !== 2'b00) begin
            errors++; $display("FAIL conc_addr got=%b/%h/%b/%h/%b/%b", m_arvalid, m_araddr, m_awvalid, m_awaddr, s_awready, s_wready);
        end
        @(negedge clk); s_arvalid = 2'b00; s_awvalid = 2'b00;
        m_rvalid = 1'b1; m_rdata = 32'h77; m_rlast = 1'b1; m_rid = 4'h1; #1;
        checks++;
        if (s_rvalid !== 2'b01 || s_rdata[31:0] !== 32'h77) begin
            errors++; $display("FAIL conc_read got=%b/%h exp=01/77", s_rvalid, s_rdata);
        end
        checks++;
        if (m_wvalid !== 1'b1 || m_wdata !== 32'hCAFE || m_wstrb !== 4'hF || m_wlast !== 1'b1 || s_wready !== 2'b10) begin
            errors++; $display("FAIL conc_wdata got=%b/%h/%h/%b/%b exp=1/cafe/f/1/10", m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready);
        end
        @(negedge clk); s_wvalid = 2'b00; s_wlast = 2'b00; m_rvalid = 1'b0; m_rlast = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b11; m_bid = 4'h6; #1;
        checks++;
        if (s_bvalid !== 2'b10 || s_bresp !== 4'b1100 || s_bid !== 8'h60 || m_bready !== 1'b1) begin
            errors++; $display("FAIL conc_bresp got=%b/%b/%h/%b exp=10/1100/60/1", s_bvalid, s_bresp, s_bid, m_bready);
        end
        @(negedge clk); m_bvalid = 1'b0; m_bresp = 2'b00; #1;
        checks++;
        if ({m_bready, m_wvalid, m_awvalid, m_rready} !== 4'b0) begin
            errors++; $display("FAIL conc_done got=%b exp=0000", {m_bready, m_wvalid, m_awvalid, m_rready});
        end
    endtask

    task automatic test_w_early();
        @(negedge clk); s_wvalid = 2'b01; s_wlast = 2'b01; s_wdata = 64'h55; s_wstrb = 8'h0F; #1;
        checks++;
        if (s_wready !== 2'b00) begin
            errors++; $display("FAIL wearly_c1 got=%b exp=00", s_wready);
        end
        @(negedge clk); #1;
        checks++;
        if (s_wready !== 2'b00 || m_wvalid !== 1'b0) begin
            errors++; $display("FAIL wearly_c2 got=%b/%b exp=00/0", s_wready, m_wvalid);
        end
        @(negedge clk); s_awvalid = 2'b01; #1;
        @(negedge clk); #1;
        checks++;
        if (m_awvalid !== 1'b1 || m_awaddr !== 32'h3000 || s_awready !== 2'b01 || s_wready !== 2'b00) begin
            errors++; $display("FAIL wearly_aw got=%b/%h/%b/%b exp=1/3000/01/00", m_awvalid, m_awaddr, s_awready, s_wready);
        end
        @(negedge clk); s_awvalid = 2'b00; #1;
        checks++;
        if (s_wready !== 2'b01 || m_wvalid !== 1'b1 || m_wdata !== 32'h55 || m_wstrb !== 4'hF) begin
            errors++; $display("FAIL wearly_w got=%b/%b/%h/%h exp=01/1/55/f", s_wready, m_wvalid, m_wdata, m_wstrb);
        end
        @(negedge clk); s_wvalid = 2'b00; s_wlast = 2'b00; m_bvalid = 1'b1; m_bresp = 2'b00; m_bid = 4'h5; #1;
        checks++;
        if (s_bvalid !== 2'b01 || s_bid !== 8'h05 || s_wready !== 2'b00) begin
            errors++; $display("FAIL wearly_b got=%b/%h/%b exp=01/05/00", s_bvalid, s_bid, s_wready);
        end
        @(negedge clk); m_bvalid = 1'b0;
    endtask

    task automatic test_rr4();
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        int cnt [4]     = '{0, 0, 0, 0};
        int c;
        @(negedge clk);
        q_s_arvalid = 4'hF; q_m_arready = 1'b1; q_m_rvalid = 1'b1; q_m_rlast = 1'b1; q_s_rready = 4'hF; #1;
        for (int g = 0; g < 5; g++) begin
            c = 0;
            while (q_m_arvalid !== 1'b1 && c < 10) begin
                @(negedge clk); #1; c++;
            end
            checks++;
            if (q_m_arvalid !== 1'b1 || q_m_arid !== 4'(exp_ord[g])) begin
                errors++; $display("FAIL rr4_order%0d got=%b/%0d exp=1/%0d", g, q_m_arvalid, q_m_arid, exp_ord[g]);
            end
            if (g < 4 && q_m_arvalid === 1'b1 && q_m_arid < 4'd4) cnt[q_m_arid[1:0]]++;
            @(negedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cnt[k] != 1) begin
                errors++; $display("FAIL rr4_count%0d got=%0d exp=1", k, cnt[k]);
            end
        end
        q_s_arvalid = 4'h0; q_m_rvalid = 1'b0; q_m_rlast = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); s_arvalid = 2'b10; s_arlen = 16'h0300;
        @(negedge clk); #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h2000) begin
            errors++; $display("FAIL rstmid_grant got=%b/%h exp=1/2000", m_arvalid, m_araddr);
        end
        @(negedge clk); s_arvalid = 2'b00; m_rvalid = 1'b1; m_rdata = 32'h1; m_rlast = 1'b0;
        @(negedge clk); m_rdata = 32'h2; #1;
        checks++;
        if (s_rvalid !== 2'b10) begin
            errors++; $display("FAIL rstmid_beat2 got=%b exp=10", s_rvalid);
        end
        @(negedge clk); reset = 1'b1; m_rdata = 32'h3;
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if ({m_arvalid, m_awvalid, m_wvalid, s_rvalid, s_bvalid, m_rready, m_bready} !== 9'b0) begin
            errors++; $display("FAIL rstmid_after got=%b exp=0", {m_arvalid, m_awvalid, m_wvalid, s_rvalid, s_bvalid, m_rready, m_bready});
        end
        m_rvalid = 1'b0; s_arlen = 16'h0; s_arvalid = 2'b11;
        @(negedge clk); #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000 || s_arready !== 2'b01) begin
            errors++; $display("FAIL rstmid_regrant got=%b/%h/%b exp=1/1000/01", m_arvalid, m_araddr, s_arready);
        end
        @(negedge clk); s_arvalid = 2'b00; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h9; #1;
        checks++;
        if (s_rvalid !== 2'b01 || s_rdata !== 64'h9) begin
            errors++; $display("FAIL rstmid_rdata got=%b/%h exp=01/9", s_rvalid, s_rdata);
        end
        @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        s_awvalid = '0; s_awaddr = {32'h4000, 32'h3000}; s_awid = {4'h6, 4'h5};
        s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_bready = 2'b11;
        s_arvalid = '0; s_araddr = {32'h2000, 32'h1000}; s_arid = {4'h2, 4'h1};
        s_arlen = '0; s_arsize = '0; s_arburst = '0; s_rready = 2'b11;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = '0; m_bid = '0;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
        q_s_arvalid = '0; q_s_arid = {4'd3, 4'd2, 4'd1, 4'd0}; q_s_rready = '0;
        q_m_arready = 1'b0; q_m_rvalid = 1'b0; q_m_rlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        test_reset();
        test_rr_two();
        test_burst();
        test_concurrent();
        test_w_early();
        test_rr4();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
